// File: rtl/ne_fp_norm_lzc_pipe.sv
// Normalization front-end: LZC + exponent clamp, 2-cycle valid/ready pipe, stalls hold outputs, in_rdy = ~s1_vld | ~s2_vld | out_rdy.
// Define NE_NORM_STAT_EN to add saturating zero/subnormal output-beat counters.
module ne_fp_norm_lzc_pipe #(
  parameter int BW_DATA = 27,
  parameter int BW_SF   = 5,
  parameter int BW_EXP  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [BW_DATA-1:0] in_mant,
  input  logic [BW_EXP-1:0]  in_exp,
  input  logic               in_sign,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [BW_DATA-1:0] out_mant,
  output logic [BW_SF-1:0]   out_shf,
  output logic [BW_EXP-1:0]  out_exp,
  output logic               out_sign,
  output logic               out_zero,
  output logic               out_sub
`ifdef NE_NORM_STAT_EN
  ,output logic [15:0]       stat_zero_cnt
  ,output logic [15:0]       stat_sub_cnt
`endif
);

  localparam int LZW = BW_SF + 1;
  localparam int CW  = (BW_EXP > LZW) ? BW_EXP : LZW;

  logic               s1_vld_q, s2_vld_q;
  logic [BW_DATA-1:0] s1_mant_q, s2_mant_q;
  logic [BW_EXP-1:0]  s1_exp_q, s2_exp_q;
  logic               s1_sign_q, s2_sign_q;
  logic [BW_SF-1:0]   s2_shf_q;
  logic               s2_zero_q, s2_sub_q;

  logic [BW_SF-1:0]   s2_shf_d;
  logic [BW_EXP-1:0]  s2_exp_d;
  logic               s2_zero_d, s2_sub_d;

  logic               s1_en, s2_en, in_xfer;
  logic [LZW-1:0]     lzc;
  logic [CW-1:0]      exp_m1, lzc_w;

  assign s2_en   = ~s2_vld_q | out_rdy;
  assign s1_en   = ~s1_vld_q | s2_en;
  assign in_rdy  = s1_en;
  assign in_xfer = in_vld & s1_en;

  // Ascending scan so the highest set bit determines the count.
  always_comb begin
    lzc = LZW'(BW_DATA);
    for (int i = 0; i < BW_DATA; i++) begin
      if (s1_mant_q[i]) lzc = LZW'(BW_DATA - 1 - i);
    end
  end

  always_comb begin
    s2_shf_d  = '0;
    s2_exp_d  = '0;
    s2_zero_d = 1'b0;
    s2_sub_d  = 1'b0;
    exp_m1    = CW'(s1_exp_q) - CW'(1);
    lzc_w     = CW'(lzc);
    if (s1_mant_q == '0) begin
      s2_zero_d = 1'b1;
    end else if (s1_exp_q == '0) begin
      s2_sub_d = 1'b1;
    end else if (lzc_w > exp_m1) begin
      // Clamped: shifting by exp-1 always lands on the minimum normal exponent.
      s2_shf_d = BW_SF'(exp_m1);
      s2_exp_d = BW_EXP'(1);
      s2_sub_d = 1'b1;
    end else begin
      s2_shf_d = BW_SF'(lzc);
      s2_exp_d = s1_exp_q - BW_EXP'(lzc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_mant_q <= '0;
      s1_exp_q  <= '0;
      s1_sign_q <= 1'b0;
    end else begin
      if (s1_en) s1_vld_q <= in_xfer;
      if (in_xfer) begin
        s1_mant_q <= in_mant;
        s1_exp_q  <= in_exp;
        s1_sign_q <= in_sign;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s2_mant_q <= '0;
      s2_shf_q  <= '0;
      s2_exp_q  <= '0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_sub_q  <= 1'b0;
    end else if (s2_en) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_mant_q <= s1_mant_q;
        s2_shf_q  <= s2_shf_d;
        s2_exp_q  <= s2_exp_d;
        s2_sign_q <= s1_sign_q;
        s2_zero_q <= s2_zero_d;
        s2_sub_q  <= s2_sub_d;
      end
    end
  end

  assign out_vld  = s2_vld_q;
  assign out_mant = s2_mant_q;
  assign out_shf  = s2_shf_q;
  assign out_exp  = s2_exp_q;
  assign out_sign = s2_sign_q;
  assign out_zero = s2_zero_q;
  assign out_sub  = s2_sub_q;

`ifdef NE_NORM_STAT_EN
  logic [15:0] zero_cnt_q, sub_cnt_q;
  logic        out_hs;

  assign out_hs = s2_vld_q & out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt_q <= '0;
      sub_cnt_q  <= '0;
    end else begin
      if (out_hs && s2_zero_q && zero_cnt_q != 16'hFFFF) zero_cnt_q <= zero_cnt_q + 16'd1;
      if (out_hs && s2_sub_q && sub_cnt_q != 16'hFFFF) sub_cnt_q <= sub_cnt_q + 16'd1;
    end
  end

  assign stat_zero_cnt = zero_cnt_q;
  assign stat_sub_cnt  = sub_cnt_q;
`endif

endmodule

// File: tb/tb_ne_fp_norm_lzc_pipe.sv
// Bench for ne_fp_norm_lzc_pipe: queue scoreboard fed by an independent LZC/clamp model.
module tb_ne_fp_norm_lzc_pipe;

  typedef struct packed {
    logic [26:0] mant;
    logic [4:0]  shf;
    logic [9:0]  exp;
    logic        sign;
    logic        zero;
    logic        sub;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [26:0] in_mant = '0;
  logic [9:0]  in_exp = '0;
  logic        in_sign = 1'b0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [26:0] out_mant;
  logic [4:0]  out_shf;
  logic [9:0]  out_exp;
  logic        out_sign, out_zero, out_sub;
`ifdef NE_NORM_STAT_EN
  logic [15:0] stat_zero_cnt, stat_sub_cnt;
`endif

  beat_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  logic  hs_in, hs_out;

  always #5 clk = ~clk;

  ne_fp_norm_lzc_pipe #(.BW_DATA(27), .BW_SF(5), .BW_EXP(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_mant(out_mant), .out_shf(out_shf), .out_exp(out_exp),
    .out_sign(out_sign), .out_zero(out_zero), .out_sub(out_sub)
`ifdef NE_NORM_STAT_EN
    ,.stat_zero_cnt(stat_zero_cnt), .stat_sub_cnt(stat_sub_cnt)
`endif
  );

  function automatic beat_t model(logic [26:0] m, logic [9:0] e, logic s);
    beat_t r;
    int lz;
    int ei;
    r = '0;
    r.mant = m;
    r.sign = s;
    lz = 0;
    while (lz < 27) begin
      if (m[26-lz]) break;
      lz++;
    end
    ei = int'(e);
    if (m == 0) begin
      r.zero = 1'b1;
    end else if (ei == 0) begin
      r.sub = 1'b1;
    end else begin
      if (lz > ei - 1) begin
        r.shf = 5'(ei - 1);
        r.sub = 1'b1;
      end else begin
        r.shf = 5'(lz);
      end
      r.exp = 10'(ei - int'(r.shf));
    end
    return r;
  endfunction

  // Called at a negedge with inputs already driven; scores handshakes of the coming posedge.
  task automatic tick();
    beat_t got, exp_b;
    #1;
    hs_in  = in_vld & in_rdy;
    hs_out = out_vld & out_rdy;
    if (hs_in) sb_q.push_back(model(in_mant, in_exp, in_sign));
    if (hs_out) begin
      checks++;
      got.mant = out_mant; got.shf = out_shf; got.exp = out_exp;
      got.sign = out_sign; got.zero = out_zero; got.sub = out_sub;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got beat %h, required no output", got);
      end else begin
        exp_b = sb_q.pop_front();
        if (got !== exp_b) begin
          errors++;
          $display("FAIL sb_beat: got %h required %h", got, exp_b);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(string name);
    int n;
    in_vld = 1'b0;
    out_rdy = 1'b1;
    n = 0;
    while ((sb_q.size() != 0 || out_vld) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending beats, required 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_vld = 1'b0;
    out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_vld !== 1'b0) begin
      errors++; $display("FAIL reset_vld: got %b required 0", out_vld);
    end
    checks++;
    if ({out_mant, out_shf, out_exp, out_sign, out_zero, out_sub} !== '0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h required 0", out_mant, out_shf, out_exp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_in_rdy: got %b required 1", in_rdy);
    end
  endtask

  task automatic check_norm(string name, logic [26:0] m, logic [9:0] e, logic s,
                            logic [4:0] eshf, logic [9:0] eexp, logic ezero, logic esub);
    int n;
    out_rdy = 1'b1;
    in_mant = m; in_exp = e; in_sign = s; in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    n = 1;
    while (!out_vld && n < 8) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 2) begin
      errors++; $display("FAIL %s_latency: got %0d cycles required 2", name, n);
    end
    checks++;
    if ({out_shf, out_exp, out_zero, out_sub, out_sign} !== {eshf, eexp, ezero, esub, s}) begin
      errors++;
      $display("FAIL %s_value: got shf=%0d exp=%0d zero=%b sub=%b required shf=%0d exp=%0d zero=%b sub=%b",
               name, out_shf, out_exp, out_zero, out_sub, eshf, eexp, ezero, esub);
    end
    tick();
  endtask

  task automatic test_directed();
    check_norm("bit22",   27'h0400000, 10'd100, 1'b0, 5'd4, 10'd96, 1'b0, 1'b0);
    check_norm("clamp",   27'h0000001, 10'd10,  1'b1, 5'd9, 10'd1,  1'b0, 1'b1);
    check_norm("zero",    27'h0000000, 10'd55,  1'b0, 5'd0, 10'd0,  1'b1, 1'b0);
    check_norm("exp0",    27'h4000000, 10'd0,   1'b1, 5'd0, 10'd0,  1'b0, 1'b1);
    check_norm("msb",     27'h4000000, 10'd20,  1'b0, 5'd0, 10'd20, 1'b0, 1'b0);
    check_norm("exp1",    27'h0000100, 10'd1,   1'b0, 5'd0, 10'd1,  1'b0, 1'b1);
    drain("directed");
  endtask

  task automatic test_back_to_back();
    int outs, gaps, first;
    logic [26:0] snap_mant;
    logic [9:0]  snap_exp;
    int acc;
    out_rdy = 1'b1;
    outs = 0; gaps = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      in_vld = (i < 8);
      in_mant = 27'h7FFFFFF >> i;
      in_exp = 10'(30 + i);
      in_sign = i[0];
      tick();
      if (hs_out) begin
        if (first < 0) first = i;
        outs++;
      end else if (first >= 0 && outs < 8) begin
        gaps++;
      end
    end
    checks++;
    if (outs !== 8 || gaps !== 0 || first !== 2) begin
      errors++; $display("FAIL b2b_stream: got outs=%0d gaps=%0d first=%0d required 8/0/2", outs, gaps, first);
    end
    drain("b2b");

    out_rdy = 1'b0;
    in_vld = 1'b1;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      in_mant = 27'h0001000 << i;
      in_exp = 10'(200 + i);
      tick();
      if (hs_in) acc++;
      if (i == 1) begin
        snap_mant = out_mant;
        snap_exp = out_exp;
      end
    end
    checks++;
    if (acc !== 2 || in_rdy !== 1'b0) begin
      errors++; $display("FAIL stall_accepts: got acc=%0d in_rdy=%b required 2/0", acc, in_rdy);
    end
    checks++;
    if (out_vld !== 1'b1 || out_mant !== snap_mant || out_exp !== snap_exp) begin
      errors++; $display("FAIL stall_hold: got %h/%0d required %h/%0d", out_mant, out_exp, snap_mant, snap_exp);
    end
    drain("stall");
  endtask

  task automatic test_random();
    int sent, n;
    logic [31:0] r;
    sent = 0; n = 0;
    hs_in = 1'b1;
    in_vld = 1'b0;
    while (sent < 4000 && n < 40000) begin
      if (!in_vld || hs_in) begin
        in_vld = ($urandom_range(0, 3) != 0);
        r = $urandom;
        in_mant = ($urandom_range(0, 15) == 0) ? 27'h0 : 27'(r >> $urandom_range(0, 28));
        in_exp = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(0, 30)) : 10'($urandom_range(0, 1023));
        in_sign = r[31];
      end
      out_rdy = ($urandom_range(0, 3) != 0);
      tick();
      if (hs_in) sent++;
      n++;
    end
    checks++;
    if (sent !== 4000) begin
      errors++; $display("FAIL random_budget: got %0d beats required 4000", sent);
    end
    drain("random");
  endtask

  task automatic test_reset_midstream();
    out_rdy = 1'b0;
    in_vld = 1'b1;
    in_mant = 27'h0123456; in_exp = 10'd77;
    tick();
    in_mant = 27'h0000F00; in_exp = 10'd88;
    tick();
    in_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_vld !== 1'b0) begin
      errors++; $display("FAIL rst_mid_vld: got %b required 0", out_vld);
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_norm("post_rst", 27'h0000040, 10'd300, 1'b1, 5'd20, 10'd280, 1'b0, 1'b0);
    drain("post_rst");
  endtask

`ifdef NE_NORM_STAT_EN
  task automatic test_stat();
    out_rdy = 1'b1;
    in_vld = 1'b1;
    in_mant = '0; in_exp = 10'd5;
    for (int i = 0; i < 70000; i++) tick();
    drain("stat");
    checks++;
    if (stat_zero_cnt !== 16'hFFFF || stat_sub_cnt === 16'hFFFF) begin
      errors++; $display("FAIL stat_sat: got zero=%h sub=%h required FFFF/not saturated", stat_zero_cnt, stat_sub_cnt);
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midstream();
`ifdef NE_NORM_STAT_EN
    test_stat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
